// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction-memory geometry, fetch FSM encoding and
// the instruction word type used by the fetch stage.
package cpu_pkg;

    localparam int ADDR_W = 6;

    localparam logic [ADDR_W-1:0] RESET_PC = 6'd0;
    localparam logic [ADDR_W-1:0] LAST_PC  = 6'd44;
    localparam logic [ADDR_W-1:0] PC_STEP  = 6'd4;

    typedef logic [31:0]       instr_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DONE,
        FAULT
    } fetch_state_t;

    // A redirect target must be word aligned and inside the program image.
    function automatic logic bad_target(input addr_t target);
        return (target[1:0] != 2'b00) || (target > LAST_PC);
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for an instruction word and its address, used to
// park the in-flight memory word while decode is stalled.
module fetch_skid_buf
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [31:0]       load_data,
    input  logic [ADDR_W-1:0] load_pc,
    output logic              valid,
    output logic [31:0]       data,
    output logic [ADDR_W-1:0] pc
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end
    end

    // NOTE: the payload is not reset; valid alone qualifies it, so a reset on
    // these wide registers would only cost routing.
    always_ff @(posedge clk) begin
        if (load) begin
            data <= load_data;
            pc   <= load_pc;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch controller: owns the PC, tracks the one-cycle memory read
// latency, and hands words to decode through a valid/stall handshake.
module fetch_sequencer
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    output logic              done,
    output logic              fault
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              infl_q, infl_d;
    logic [ADDR_W-1:0] infl_pc_q, infl_pc_d;

    logic              skid_v;
    logic              skid_load;
    logic              skid_clear;
    logic [31:0]       skid_data;
    logic [ADDR_W-1:0] skid_pc;

    logic              active;
    logic              accept;

    fetch_skid_buf u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load),
        .clear     (skid_clear),
        .load_data (imem_data),
        .load_pc   (infl_pc_q),
        .valid     (skid_v),
        .data      (skid_data),
        .pc        (skid_pc)
    );

    assign imem_addr = pc_q;
    assign active    = (state_q == RUN) || (state_q == DRAIN);
    assign done      = (state_q == DONE);
    assign fault     = (state_q == FAULT);

    // The skid entry always takes precedence: it holds the older word.
    always_comb begin
        instr       = '0;
        instr_pc    = '0;
        instr_valid = 1'b0;
        if (active) begin
            if (skid_v) begin
                instr       = skid_data;
                instr_pc    = skid_pc;
                instr_valid = 1'b1;
            end else if (infl_q) begin
                instr       = imem_data;
                instr_pc    = infl_pc_q;
                instr_valid = 1'b1;
            end
        end
    end

    assign accept = instr_valid && !stall;

    // NOTE: every combinational output gets a default first so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        infl_d     = 1'b0;
        infl_pc_d  = infl_pc_q;
        skid_load  = 1'b0;
        skid_clear = 1'b0;

        if (active) begin
            if (redirect_valid) begin
                // Both buffered words belong to the abandoned path.
                skid_clear = 1'b1;
                if (bad_target(redirect_pc)) begin
                    state_d = FAULT;
                end else begin
                    pc_d    = redirect_pc;
                    state_d = RUN;
                end
            end else begin
                if (stall && infl_q && !skid_v) begin
                    skid_load = 1'b1;
                end
                if (skid_v && !stall) begin
                    skid_clear = 1'b1;
                end
                if (state_q == DRAIN && accept) begin
                    state_d = DONE;
                end
                if (state_q == RUN && !stall && !skid_v) begin
                    infl_d    = 1'b1;
                    infl_pc_d = pc_q;
                    if (pc_q == LAST_PC) begin
                        state_d = DRAIN;
                    end else begin
                        pc_d = pc_q + PC_STEP;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            infl_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            infl_q  <= infl_d;
        end
    end

    always_ff @(posedge clk) begin
        infl_pc_q <= infl_pc_d;
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: transaction-level reference model,
// per-cycle comparison, directed boundary scenarios and randomized traffic.
module tb_fetch_sequencer;

    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_DONE  = 2;
    localparam int M_FAULT = 3;

    typedef struct packed {
        logic [1:0] st;
        logic [5:0] next;
        logic       has;
        logic       held;
        logic [5:0] wpc;
    } model_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  imem_addr;
    logic [31:0] imem_data;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [5:0]  redirect_pc = '0;
    logic [31:0] instr;
    logic [5:0]  instr_pc;
    logic        instr_valid;
    logic        done;
    logic        fault;

    logic [31:0] mem [16];
    model_t      m;
    int          total = 0;
    int          bad   = 0;

    fetch_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .done           (done),
        .fault          (fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_data <= mem[imem_addr[5:2]];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic model_t model_reset();
        model_t r;
        r.st   = 2'(M_RUN);
        r.next = 6'd0;
        r.has  = 1'b0;
        r.held = 1'b0;
        r.wpc  = 6'd0;
        return r;
    endfunction

    // Word-level view: one presented word at most; a word that sat through a
    // stalled edge costs one bubble before the next issue.
    function automatic model_t model_step(input model_t c, input logic s,
                                          input logic rv, input logic [5:0] rpc);
        model_t n = c;
        if (c.st == 2'(M_DONE) || c.st == 2'(M_FAULT)) return n;
        if (rv) begin
            n.has  = 1'b0;
            n.held = 1'b0;
            if ((rpc % 4) != 0 || rpc > 6'd44) begin
                n.st = 2'(M_FAULT);
            end else begin
                n.st   = 2'(M_RUN);
                n.next = rpc;
            end
            return n;
        end
        if (c.has && s) begin
            n.held = 1'b1;
            return n;
        end
        if (c.has) begin
            n.has  = 1'b0;
            n.held = 1'b0;
            if (c.st == 2'(M_DRAIN)) n.st = 2'(M_DONE);
        end
        if (c.st == 2'(M_RUN) && !s && !c.held) begin
            n.has = 1'b1;
            n.wpc = c.next;
            if (c.next == 6'd44) n.st = 2'(M_DRAIN);
            else n.next = c.next + 6'd4;
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= model_reset();
        else     m <= model_step(m, stall, redirect_valid, redirect_pc);
    end

    always @(negedge clk) begin
        if (rst) begin
            check("rst_valid", 64'(instr_valid), 64'd0);
            check("rst_instr", 64'(instr), 64'd0);
            check("rst_pc", 64'(instr_pc), 64'd0);
            check("rst_flags", {62'd0, done, fault}, 64'd0);
        end else begin
            logic ev;
            ev = m.has && (m.st == 2'(M_RUN) || m.st == 2'(M_DRAIN));
            check("mdl_valid", 64'(instr_valid), 64'(ev));
            check("mdl_addr", 64'(imem_addr), 64'(m.next));
            check("mdl_done", 64'(done), 64'(m.st == 2'(M_DONE)));
            check("mdl_fault", 64'(fault), 64'(m.st == 2'(M_FAULT)));
            if (ev) begin
                check("mdl_pc", 64'(instr_pc), 64'(m.wpc));
                check("mdl_instr", 64'(instr), 64'(mem[m.wpc[5:2]]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int done_wait;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;

        // Straight-line program: pcs 0..44 back to back, then done.
        do_reset();
        for (int k = 0; k < 12; k++) begin
            tick();
            check("seq_valid", 64'(instr_valid), 64'd1);
            check("seq_pc", 64'(instr_pc), 64'(4 * k));
            check("seq_instr", 64'(instr), 64'(mem[k]));
        end
        tick();
        check("seq_done", 64'(done), 64'd1);
        check("seq_tail_valid", 64'(instr_valid), 64'd0);
        tick();
        check("seq_done_sticky", 64'(done), 64'd1);

        // Stall three cycles while pc 8 is in flight.
        do_reset();
        tick(); tick(); tick();
        check("stall_pre_pc", 64'(instr_pc), 64'd8);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_hold_pc", 64'(instr_pc), 64'd8);
            check("stall_hold_instr", 64'(instr), 64'(mem[2]));
            check("stall_hold_addr", 64'(imem_addr), 64'd12);
        end
        stall = 1'b0;
        tick();
        check("stall_bubble", 64'(instr_valid), 64'd0);
        tick();
        check("stall_next_pc", 64'(instr_pc), 64'd12);
        check("stall_next_instr", 64'(instr), 64'(mem[3]));

        // Redirect to 32 while pc 12 is in flight under stall.
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 6'd32;
        tick();
        redirect_valid = 1'b0;
        stall = 1'b0;
        check("redir_gap", 64'(instr_valid), 64'd0);
        tick();
        check("redir_valid", 64'(instr_valid), 64'd1);
        check("redir_pc", 64'(instr_pc), 64'd32);

        // Misaligned target faults; later redirects are ignored.
        redirect_valid = 1'b1;
        redirect_pc = 6'd6;
        tick();
        check("fault_set", 64'(fault), 64'd1);
        check("fault_valid", 64'(instr_valid), 64'd0);
        redirect_pc = 6'd0;
        tick();
        redirect_valid = 1'b0;
        tick(); tick();
        check("fault_sticky", 64'(fault), 64'd1);
        check("fault_still_invalid", 64'(instr_valid), 64'd0);

        // Asynchronous reset with the skid entry occupied.
        do_reset();
        tick(); tick();
        stall = 1'b1;
        tick(); tick();
        check("skid_full_pc", 64'(instr_pc), 64'd4);
        #1 rst = 1'b1;
        #1;
        check("async_valid", 64'(instr_valid), 64'd0);
        check("async_instr", 64'(instr), 64'd0);
        check("async_pc", 64'(instr_pc), 64'd0);
        stall = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("restart_pc", 64'(instr_pc), 64'd0);
        check("restart_valid", 64'(instr_valid), 64'd1);

        // Redirect to the last word, stall through DRAIN.
        redirect_valid = 1'b1;
        redirect_pc = 6'd44;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("drain_pc", 64'(instr_pc), 64'd44);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("drain_hold_instr", 64'(instr), 64'(mem[11]));
            check("drain_not_done", 64'(done), 64'd0);
        end
        stall = 1'b0;
        tick();
        check("drain_done", 64'(done), 64'd1);
        check("drain_invalid", 64'(instr_valid), 64'd0);

        // Target beyond the last word faults.
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc = 6'd48;
        tick();
        redirect_valid = 1'b0;
        check("range_fault", 64'(fault), 64'd1);

        // Randomized traffic against the model.
        do_reset();
        done_wait = 0;
        for (int c = 0; c < 3000; c++) begin
            stall = ($urandom_range(0, 99) < 30);
            redirect_valid = ($urandom_range(0, 99) < 8);
            if ($urandom_range(0, 9) < 7) redirect_pc = 6'($urandom_range(0, 11) * 4);
            else redirect_pc = 6'($urandom_range(0, 63));
            if (m.st == 2'(M_DONE) || m.st == 2'(M_FAULT)) done_wait++;
            if (done_wait > 3 || $urandom_range(0, 199) == 0) begin
                done_wait = 0;
                do_reset();
            end else begin
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
